// File: rtl/uart_pkg.sv
// Shared UART definitions for the quotient TX stage and the future RX stage.
// Contents: the TX state encoding, the default bit period and the 8N1 frame
// constants.
package uart_pkg;

    // Three-bit octal codes, in the same style as the divider FSM.
    typedef enum logic [2:0] {
        IDLE  = 3'o0,
        START = 3'o1,
        DATA  = 3'o2,
        STOP  = 3'o3
    } tx_state_t;

    // 100 MHz clock, 115200 baud.
    localparam int CLKS_PER_BIT_DEF = 868;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// UART bit-period timer.
// Counts clock cycles 0..CLKS_PER_BIT-1 while run is high and wraps.
// The counter is held at 0 while run is low, so the first period after run
// rises is a full CLKS_PER_BIT cycles long.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   run      enable; 0 holds the counter at 0
//   bit_tick one-cycle pulse on the wrap cycle (last cycle of a bit period)
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_cnt <= '0;
        end else if (!run || clk_cnt == LAST) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    assign bit_tick = run && (clk_cnt == LAST);

endmodule

// File: rtl/quot_uart_tx.sv
// Quotient UART transmitter.
// Captures the divider's 16-bit quotient on its one-cycle done strobe and
// sends it as two back-to-back 8N1 frames (high byte first when HI_FIRST=1).
// A strobe arriving while a transfer is in progress is dropped and sets a
// sticky overrun flag.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (0 = in reset)
//   quot       quotient from the divider, sampled only on the capture cycle
//   quot_valid one-cycle strobe qualifying quot
//   ovr_clr    synchronous clear of overrun (a coincident overrun event wins)
//   tx         UART serial output, idle high, registered
//   busy       high for the whole two-byte transfer, registered
//   overrun    sticky drop indicator, registered
module quot_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit HI_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] quot,
    input  logic        quot_valid,
    input  logic        ovr_clr,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_t            state;
    logic [15:0]          hold;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_idx;
    logic                 byte_idx;
    logic                 run;
    logic                 bit_tick;

    // Byte 0 is the first byte on the line, byte 1 the second.
    function automatic logic [7:0] pick_byte(input logic [15:0] q, input logic second);
        return (second == HI_FIRST) ? q[7:0] : q[15:8];
    endfunction

    // The timer only runs outside IDLE, so it is at 0 on every capture edge.
    assign run = (state != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            hold     <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
        end else begin
            // Set has priority over clear.
            if (quot_valid && state != IDLE) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (quot_valid) begin
                        hold     <= quot;
                        shift    <= pick_byte(quot, 1'b0);
                        byte_idx <= 1'b0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Present the next bit directly from the
                            // pre-shift value so tx stays registered.
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[DATA_BITS-1:1]};
                            tx      <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (!byte_idx) begin
                            byte_idx <= 1'b1;
                            shift    <= pick_byte(hold, 1'b1);
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            byte_idx <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quot_uart_tx.sv
// Directed testbench for quot_uart_tx.
// Three instances share the stimulus: a fast high-byte-first unit, a fast
// low-byte-first unit and one at the default 868-cycle bit period. Every
// test starts from a fresh reset, so the idle instances do not disturb it.
module tb_quot_uart_tx;

    localparam int MAXC = 17500;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] quot = '0;
    logic        quot_valid = 1'b0;
    logic        ovr_clr = 1'b0;

    logic tx_a, busy_a, ovr_a;
    logic tx_b, busy_b, ovr_b;
    logic tx_c, busy_c, ovr_c;

    int n_vec = 0;
    int n_err = 0;

    logic tx_log   [0:MAXC-1];
    logic busy_log [0:MAXC-1];
    logic ovr_log  [0:MAXC-1];

    always #5 clk = ~clk;

    quot_uart_tx #(.CLKS_PER_BIT(4), .HI_FIRST(1'b1)) dut_hi (
        .clk(clk), .reset(reset), .quot(quot), .quot_valid(quot_valid),
        .ovr_clr(ovr_clr), .tx(tx_a), .busy(busy_a), .overrun(ovr_a)
    );

    quot_uart_tx #(.CLKS_PER_BIT(4), .HI_FIRST(1'b0)) dut_lo (
        .clk(clk), .reset(reset), .quot(quot), .quot_valid(quot_valid),
        .ovr_clr(ovr_clr), .tx(tx_b), .busy(busy_b), .overrun(ovr_b)
    );

    quot_uart_tx #(.CLKS_PER_BIT(868), .HI_FIRST(1'b1)) dut_slow (
        .clk(clk), .reset(reset), .quot(quot), .quot_valid(quot_valid),
        .ovr_clr(ovr_clr), .tx(tx_c), .busy(busy_c), .overrun(ovr_c)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        quot_valid = 1'b0;
        ovr_clr = 1'b0;
        quot = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Strobes q for one cycle, then logs one instance's outputs after each
    // of the following ncyc edges (entry k is after capture edge + k).
    // A second strobe is driven for edges k in [v_from+1, v_to+1] with
    // quot = v_quot, and ovr_clr for edge clr_at+1.
    task automatic capture(input int which, input logic [15:0] q, input int ncyc,
                           input int v_from, input int v_to,
                           input logic [15:0] v_quot, input int clr_at);
        quot = q;
        quot_valid = 1'b1;
        @(posedge clk);
        #1;
        quot_valid = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            case (which)
                0: begin tx_log[k] = tx_a; busy_log[k] = busy_a; ovr_log[k] = ovr_a; end
                1: begin tx_log[k] = tx_b; busy_log[k] = busy_b; ovr_log[k] = ovr_b; end
                default: begin tx_log[k] = tx_c; busy_log[k] = busy_c; ovr_log[k] = ovr_c; end
            endcase
            quot_valid = (k >= v_from) && (k <= v_to);
            if (k == v_from) quot = v_quot;
            ovr_clr = (k == clr_at);
        end
        quot_valid = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || ovr_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got tx=%b busy=%b ovr=%b want 1 0 0", tx_a, busy_a, ovr_a);
        end
        apply_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_vec++;
            if ({tx_a, busy_a, ovr_a, tx_b, busy_b, ovr_b, tx_c, busy_c, ovr_c} !== 9'b100_100_100) begin
                n_err++;
                $display("FAIL idle[%0d]: got %b%b%b %b%b%b %b%b%b want 100 100 100", k,
                         tx_a, busy_a, ovr_a, tx_b, busy_b, ovr_b, tx_c, busy_c, ovr_c);
            end
        end
        // Mid-frame reset: cycle 10 of A53C is the 2nd data bit (0).
        quot = 16'hA53C;
        quot_valid = 1'b1;
        @(posedge clk);
        #1;
        quot_valid = 1'b0;
        repeat (11) @(negedge clk);
        n_vec++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_pre: got tx=%b busy=%b want 0 1", tx_a, busy_a);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_async: got tx=%b busy=%b want 1 0", tx_a, busy_a);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_hi_first();
        logic [0:19] fr;
        fr = 20'b0101001011_0001111001;
        apply_reset();
        capture(0, 16'hA53C, 84, -1, -1, 16'h0000, -1);
        for (int k = 0; k < 84; k++) begin
            n_vec++;
            if (tx_log[k] !== ((k < 80) ? fr[k/4] : 1'b1) || busy_log[k] !== (k < 80) || ovr_log[k] !== 1'b0) begin
                n_err++;
                $display("FAIL hi_first[%0d]: got tx=%b busy=%b ovr=%b want tx=%b busy=%b ovr=0", k,
                         tx_log[k], busy_log[k], ovr_log[k], (k < 80) ? fr[k/4] : 1'b1, k < 80);
            end
        end
    endtask

    task automatic test_lo_first();
        logic [0:19] fr;
        fr = 20'b0111111111_0000000001;
        apply_reset();
        capture(1, 16'h00FF, 84, -1, -1, 16'h0000, -1);
        for (int k = 0; k < 84; k++) begin
            n_vec++;
            if (tx_log[k] !== ((k < 80) ? fr[k/4] : 1'b1) || busy_log[k] !== (k < 80)) begin
                n_err++;
                $display("FAIL lo_first[%0d]: got tx=%b busy=%b want tx=%b busy=%b", k,
                         tx_log[k], busy_log[k], (k < 80) ? fr[k/4] : 1'b1, k < 80);
            end
        end
    endtask

    task automatic test_overrun();
        logic [0:19] fr;
        fr = 20'b0101001011_0001111001;
        apply_reset();
        // Strobe 1234 sampled at capture edge + 10, clear at capture edge + 31.
        capture(0, 16'hA53C, 84, 9, 9, 16'h1234, 30);
        for (int k = 0; k < 84; k++) begin
            n_vec++;
            if (tx_log[k] !== ((k < 80) ? fr[k/4] : 1'b1) || busy_log[k] !== (k < 80) ||
                ovr_log[k] !== ((k >= 10) && (k <= 30))) begin
                n_err++;
                $display("FAIL overrun[%0d]: got tx=%b busy=%b ovr=%b want tx=%b busy=%b ovr=%b", k,
                         tx_log[k], busy_log[k], ovr_log[k], (k < 80) ? fr[k/4] : 1'b1, k < 80,
                         (k >= 10) && (k <= 30));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:19] fa;
        logic [0:19] fc;
        logic        et;
        logic        eb;
        fa = 20'b0101001011_0001111001;
        fc = 20'b0110000111_0010110101;
        apply_reset();
        // Strobes sampled at capture edge + 80 (busy falls) and + 81.
        capture(0, 16'hA53C, 164, 79, 80, 16'hC35A, -1);
        for (int k = 0; k < 164; k++) begin
            if (k < 80) begin
                et = fa[k/4]; eb = 1'b1;
            end else if (k >= 81 && k < 161) begin
                et = fc[(k-81)/4]; eb = 1'b1;
            end else begin
                et = 1'b1; eb = 1'b0;
            end
            n_vec++;
            if (tx_log[k] !== et || busy_log[k] !== eb || ovr_log[k] !== (k >= 80)) begin
                n_err++;
                $display("FAIL b2b[%0d]: got tx=%b busy=%b ovr=%b want tx=%b busy=%b ovr=%b", k,
                         tx_log[k], busy_log[k], ovr_log[k], et, eb, k >= 80);
            end
        end
    endtask

    task automatic test_slow();
        logic [0:19] fr;
        fr = 20'b0000000001_0100000001;
        apply_reset();
        capture(2, 16'h0001, 17365, -1, -1, 16'h0000, -1);
        for (int k = 0; k < 17365; k++) begin
            n_vec++;
            if (tx_log[k] !== ((k < 17360) ? fr[k/868] : 1'b1) || busy_log[k] !== (k < 17360)) begin
                n_err++;
                $display("FAIL slow[%0d]: got tx=%b busy=%b want tx=%b busy=%b", k,
                         tx_log[k], busy_log[k], (k < 17360) ? fr[k/868] : 1'b1, k < 17360);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hi_first();
        test_lo_first();
        test_overrun();
        test_back_to_back();
        test_slow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
